// File: rtl/fd_instr_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The master modport is the fetch/decode side and the slave modport is the queue.
interface fd_instr_queue_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             f_valid;
    logic [31:0]      f_pc;
    logic [31:0]      f_instr;
    logic             f_ready;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic             d_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    modport master (
        output f_valid, f_pc, f_instr, d_ready, flush,
        input  f_ready, d_valid, d_pc, d_instr, count
    );

    modport slave (
        input  f_valid, f_pc, f_instr, d_ready, flush,
        output f_ready, d_valid, d_pc, d_instr, count
    );
endinterface

// File: rtl/fd_instr_queue.sv
// First-word-fall-through (PC, instruction) queue between fetch and decode.
// All outputs are decoded from registered state; an empty queue presents a bubble.
module fd_instr_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    fd_instr_queue_if.slave io_q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;

    logic   w_full_n;
    logic   w_nonempty;
    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    assign w_full_n   = (r_count != CNT_W'(DEPTH));
    assign w_nonempty = (r_count != CNT_W'(0));
    assign w_push     = io_q.f_valid & w_full_n & ~io_q.flush;
    assign w_pop      = w_nonempty & io_q.d_ready & ~io_q.flush;
    assign w_head     = r_mem[r_rp];

    assign io_q.f_ready = w_full_n;
    assign io_q.d_valid = w_nonempty;
    assign io_q.d_pc    = w_nonempty ? w_head.pc    : PC_RESET;
    assign io_q.d_instr = w_nonempty ? w_head.instr : 32'h0000_0000;
    assign io_q.count   = r_count;

    // Storage is never cleared; stale entries are masked by d_valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= '{pc: io_q.f_pc, instr: io_q.f_instr};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || io_q.flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fd_instr_queue.sv
// Directed self-checking bench for fd_instr_queue with DEPTH = 2.
module tb_fd_instr_queue;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fd_instr_queue_if #(.DEPTH(2)) q ();

    fd_instr_queue #(.DEPTH(2), .PC_RESET(32'h0000_3000)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive(input logic fv, input logic [31:0] pc, input logic dr, input logic fl);
        q.f_valid = fv;
        q.f_pc    = pc;
        q.f_instr = ins(pc);
        q.d_ready = dr;
        q.flush   = fl;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] cnt, input logic dv,
                             input logic fr, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, ".count"},   32'(q.count),   cnt);
        chk({tag, ".d_valid"}, 32'(q.d_valid), 32'(dv));
        chk({tag, ".f_ready"}, 32'(q.f_ready), 32'(fr));
        chk({tag, ".d_pc"},    q.d_pc,         pc);
        chk({tag, ".d_instr"}, q.d_instr,      instr);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset held two cycles with fetch active
        reset = 1'b1;
        drive(1'b1, 32'h0000_5000, 1'b0, 1'b0);
        tick();
        chk_state("rst0", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        tick();
        chk_state("rst1", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        reset = 1'b0;
        drive(1'b1, 32'h0000_3000, 1'b0, 1'b0);
        tick();
        chk_state("first_push", 1, 1'b1, 1'b1, 32'h0000_3000, ins(32'h0000_3000));

        // Drain, then stream three pairs with decode ready
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_state("drain", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            chk_state($sformatf("stream%0d", i), 1, 1'b1, 1'b1,
                      32'h0000_3000 + 32'(4 * i), ins(32'h0000_3000 + 32'(4 * i)));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_state("stream_end", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);

        // Stall and fill
        drive(1'b1, 32'h0000_3000, 1'b0, 1'b0);
        tick();
        chk_state("fill1", 1, 1'b1, 1'b1, 32'h0000_3000, ins(32'h0000_3000));
        drive(1'b1, 32'h0000_3004, 1'b0, 1'b0);
        tick();
        chk_state("fill2", 2, 1'b1, 1'b0, 32'h0000_3000, ins(32'h0000_3000));
        drive(1'b1, 32'h0000_3008, 1'b0, 1'b0);
        tick();
        chk_state("full_block", 2, 1'b1, 1'b0, 32'h0000_3000, ins(32'h0000_3000));
        // Pop from full while fetch still offers: no same-cycle refill
        drive(1'b1, 32'h0000_3008, 1'b1, 1'b0);
        tick();
        chk_state("pop_full", 1, 1'b1, 1'b1, 32'h0000_3004, ins(32'h0000_3004));

        // Drain and set up count=1 with head 0x3000
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_state("drain2", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        drive(1'b1, 32'h0000_3000, 1'b0, 1'b0);
        tick();
        chk_state("one", 1, 1'b1, 1'b1, 32'h0000_3000, ins(32'h0000_3000));

        // Simultaneous push/pop, continuing across pointer wraps
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            chk_state($sformatf("pushpop%0d", i), 1, 1'b1, 1'b1,
                      32'h0000_3000 + 32'(4 * i), ins(32'h0000_3000 + 32'(4 * i)));
        end

        // Fill to two, then flush with a pair offered and decode ready
        drive(1'b1, 32'h0000_3100, 1'b0, 1'b0);
        tick();
        chk_state("pre_flush", 2, 1'b1, 1'b0, 32'h0000_3024, ins(32'h0000_3024));
        drive(1'b1, 32'h0000_4180, 1'b1, 1'b1);
        tick();
        chk_state("flush", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        drive(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        tick();
        chk_state("post_flush", 1, 1'b1, 1'b1, 32'h0000_3010, ins(32'h0000_3010));
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_state("post_flush_hold", 1, 1'b1, 1'b1, 32'h0000_3010, ins(32'h0000_3010));

        // Reset mid-operation from full
        drive(1'b1, 32'h0000_3014, 1'b0, 1'b0);
        tick();
        chk_state("pre_reset", 2, 1'b1, 1'b0, 32'h0000_3010, ins(32'h0000_3010));
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_state("mid_reset", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        reset = 1'b0;
        tick();
        chk_state("after_reset", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);

        // Reset and flush together with a pair offered
        drive(1'b1, 32'h0000_3020, 1'b0, 1'b0);
        tick();
        chk_state("pre_rstfl", 1, 1'b1, 1'b1, 32'h0000_3020, ins(32'h0000_3020));
        reset = 1'b1;
        drive(1'b1, 32'h0000_3024, 1'b1, 1'b1);
        tick();
        chk_state("rst_flush", 0, 1'b0, 1'b1, 32'h0000_3000, 32'h0);
        reset = 1'b0;
        drive(1'b1, 32'h0000_3028, 1'b0, 1'b0);
        tick();
        chk_state("after_rstfl", 1, 1'b1, 1'b1, 32'h0000_3028, ins(32'h0000_3028));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fd_instr_queue.md
# fd_instr_queue

First-word-fall-through instruction queue between the fetch stage (IFU) and the decode stage of the five-stage MIPS pipeline. It captures the (PC, instruction) pair produced by fetch each cycle and presents the oldest pair to decode. Fetch keeps running for up to DEPTH cycles while decode stalls. `f_ready` drives the IFU's PC-update enable, and `flush` discards all buffered instructions in one cycle.

## Interface
- DEPTH, 2, number of entries; power of two, ≥2
- PC_RESET, 32'h0000_3000, PC value presented on `d_pc` when the queue is empty
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; empties the queue
- f_valid  input  1  fetch presents a valid pair this cycle
- f_pc  input  32  PC of the fetched instruction
- f_instr  input  32  fetched instruction word
- f_ready  output  1  queue can accept this cycle; wired to the IFU enable
- d_valid  output  1  head entry valid for decode
- d_pc  output  32  PC of head entry
- d_instr  output  32  instruction of head entry
- d_ready  input  1  decode consumes the head this cycle (i.e. not stalled)
- flush  input  1  discard all entries and any incoming pair
- count  output  clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH × 64-bit entries {pc, instr}, plus write pointer `wp` and read pointer `rp`, each clog2(DEPTH) bits.
- Pointers wrap modulo DEPTH by natural overflow; occupancy is tracked in `count` (0..DEPTH).
- f_ready = (count != DEPTH). It is derived from registered state only, with no combinational path from `d_ready` or `flush`.
- d_valid = (count != 0).
- d_pc = entry[rp].pc when d_valid, else PC_RESET.
- d_instr = entry[rp].instr when d_valid, else 32'h0000_0000 (nop), so decode sees a bubble when the queue is empty.
- Enqueue (push) = f_valid & f_ready & ~flush:
  - entry[wp] ← {f_pc, f_instr}
  - wp ← wp+1
- Dequeue (pop) = d_valid & d_ready & ~flush:
  - rp ← rp+1
- count update:
  - push & ~pop → +1
  - pop & ~push → −1
  - both or neither → unchanged
- Push and pop in the same cycle are legal at any occupancy 1..DEPTH−1. When full, push is blocked by f_ready = 0 even if a pop occurs that cycle; there is no same-cycle refill.
- Empty: no bypass. A pair pushed into an empty queue becomes visible on d_* the next cycle.
- flush (priority below reset, above everything else), next state:
  - count = 0, wp = 0, rp = 0
  - the incoming pair is discarded even if f_valid & f_ready
  - the head is not considered consumed
- Entry storage is not cleared on reset or flush. Outputs mask it through d_valid.
- Reset, next state:
  - count = 0, wp = 0, rp = 0
  - outputs then read: f_ready = 1, d_valid = 0, d_pc = PC_RESET, d_instr = 0, count = 0
- Reset asserted mid-operation behaves identically to reset from idle. Buffered entries are lost.

## Timing
- Latency fetch → decode: 1 cycle minimum (push at edge N, visible on d_* after edge N).
- Throughput: 1 pair/cycle sustained when d_ready = 1 and count < DEPTH.
- f_ready falls the cycle after the push that fills the queue. It rises the cycle after the first pop from full.
- With d_ready = 0 from cycle 0 and f_valid = 1 continuously: exactly DEPTH pushes occur, then f_ready = 0 until a pop.
- flush at edge N: d_valid = 0 and f_ready = 1 in cycle N+1. A push in cycle N+1 is accepted normally.
- Simultaneous flush and reset: reset semantics (identical outcome).
- All outputs are combinational from registered state; d_* change only on clock edges.

## Test plan
- Reset:
  - Stimulus: assert reset 2 cycles with f_valid = 1, then release.
  - Required: during and after reset count = 0, d_valid = 0, d_pc = 32'h0000_3000, d_instr = 0, f_ready = 1.
  - Required: the first push after release appears the next cycle.
- Streaming:
  - Stimulus: d_ready = 1; push PCs 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - Required: d_pc shows 0x3000, 0x3004, 0x3008 on the following consecutive cycles; count stays ≤1.
- Stall/fill (DEPTH = 2):
  - Stimulus: d_ready = 0; push 0x3000, 0x3004, then offer 0x3008.
  - Required: count = 2, f_ready = 0, 0x3008 not accepted, head = 0x3000.
  - Stimulus: raise d_ready for one cycle.
  - Required: head becomes 0x3004; f_ready = 1 the cycle after the pop.
- Simultaneous push/pop:
  - Stimulus: count = 1 (head 0x3000); push 0x3004 and pop together.
  - Required: count stays 1, head = 0x3004.
  - Stimulus: continue across the pointer wrap for 8 cycles.
  - Required: order preserved.
- Flush:
  - Stimulus: count = 2; flush = 1 with f_valid = 1 (0x4180) and d_ready = 1.
  - Required: next cycle count = 0, d_valid = 0, d_instr = 0; 0x4180 never appears.
  - Stimulus: next push 0x3010.
  - Required: 0x3010 appears one cycle later.
- Reset mid-operation:
  - Stimulus: count = 2, d_ready = 0; assert reset for 1 cycle.
  - Required: next cycle count = 0, d_pc = 32'h0000_3000.
  - Required: previously buffered PCs never reappear on d_*.
